// File: rtl/isa_bus_sequencer.sv
// ISA bus cycle sequencer: one I/O or memory read/write per request, parametrised phase lengths.
// Optional IOCHRDY wait-state extension with timeout is enabled by defining IOCHRDY_EN.
module isa_bus_sequencer #(
   parameter int SETUP_CYCLES        = 1,
   parameter int WRITE_STROBE_CYCLES = 4,
   parameter int READ_STROBE_CYCLES  = 5,
   parameter int RECOVERY_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES      = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] control_in,
   input  logic       iochrdy,
   output logic       address_load,
   output logic       data_load,
   output logic       IOW,
   output logic       IOR,
   output logic       MEMW,
   output logic       MEMR,
   output logic       control_reset,
   output logic       busy,
   output logic       bus_error
);

   localparam int MAX_SW  = (SETUP_CYCLES > WRITE_STROBE_CYCLES) ? SETUP_CYCLES : WRITE_STROBE_CYCLES;
   localparam int MAX_RR  = (READ_STROBE_CYCLES > RECOVERY_CYCLES) ? READ_STROBE_CYCLES : RECOVERY_CYCLES;
   localparam int MAX_ALL = (MAX_SW > MAX_RR) ? MAX_SW : MAX_RR;
   localparam int CW      = $clog2(MAX_ALL + 1);

   localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] WRITE_LAST   = CW'(WRITE_STROBE_CYCLES - 1);
   localparam logic [CW-1:0] READ_LAST    = CW'(READ_STROBE_CYCLES - 1);
   localparam logic [CW-1:0] RECOVER_LAST = CW'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, STROBE, RECOVER, CTRL_RESET} state_t;

   state_t          state_q, state_d, afterStrobe;
   logic [CW-1:0]   cnt_q, cnt_d, strobeLast;
   logic            isRead_q, isRead_d, isMem_q, isMem_d;
   logic            armed_q, armed_d, busErr_q, busErr_d;
   logic            addrLoad_q, addrLoad_d, dataLoad_q, dataLoad_d;
   logic            iow_q, iow_d, ior_q, ior_d, memw_q, memw_d, memr_q, memr_d;
   logic            ctrlReset_q, ctrlReset_d, busy_q, busy_d;
   logic            rdyOk;
   logic            unusedInputs;

`ifdef IOCHRDY_EN
   localparam int            WW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] TIMEOUT_VAL = WW'(TIMEOUT_CYCLES);

   logic          sync1_q, sync2_q;
   logic [WW-1:0] wait_q, wait_d, waitInc;

   // iochrdy is asynchronous to clk; two flops before it steers the FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         wait_q  <= '0;
      end else begin
         sync1_q <= iochrdy;
         sync2_q <= sync1_q;
         wait_q  <= wait_d;
      end
   end

   assign rdyOk        = sync2_q;
   assign waitInc      = wait_q + 1'b1;
   assign unusedInputs = ^control_in[7:3];
`else
   assign rdyOk        = 1'b1;
   assign unusedInputs = ^{control_in[7:3], iochrdy, TIMEOUT_CYCLES[0]};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         isRead_q    <= 1'b0;
         isMem_q     <= 1'b0;
         armed_q     <= 1'b0;
         busErr_q    <= 1'b0;
         addrLoad_q  <= 1'b1;
         dataLoad_q  <= 1'b1;
         iow_q       <= 1'b1;
         ior_q       <= 1'b1;
         memw_q      <= 1'b1;
         memr_q      <= 1'b1;
         ctrlReset_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         isRead_q    <= isRead_d;
         isMem_q     <= isMem_d;
         armed_q     <= armed_d;
         busErr_q    <= busErr_d;
         addrLoad_q  <= addrLoad_d;
         dataLoad_q  <= dataLoad_d;
         iow_q       <= iow_d;
         ior_q       <= ior_d;
         memw_q      <= memw_d;
         memr_q      <= memr_d;
         ctrlReset_q <= ctrlReset_d;
         busy_q      <= busy_d;
      end
   end

   // Outputs are decoded from the state being entered so they switch with the state register
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      isRead_d    = isRead_q;
      isMem_d     = isMem_q;
      busErr_d    = busErr_q;
      strobeLast  = isRead_q ? READ_LAST : WRITE_LAST;
      afterStrobe = (RECOVERY_CYCLES > 0) ? RECOVER : CTRL_RESET;
`ifdef IOCHRDY_EN
      wait_d      = wait_q;
`endif

      case (state_q)
         IDLE: begin
            if (control_in[0] || control_in[1]) begin
               state_d  = ADDR;
               cnt_d    = '0;
               isRead_d = control_in[0];
               isMem_d  = control_in[2];
               busErr_d = 1'b0;
`ifdef IOCHRDY_EN
               wait_d   = '0;
`endif
            end
         end
         ADDR: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = isRead_q ? STROBE : WDATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WDATA: begin
            state_d = STROBE;
            cnt_d   = '0;
         end
         STROBE: begin
            if (cnt_q != strobeLast) begin
               cnt_d = cnt_q + 1'b1;
            end else if (armed_q) begin
               state_d = afterStrobe;
               cnt_d   = '0;
            end else begin
`ifdef IOCHRDY_EN
               wait_d = waitInc;
               if (waitInc == TIMEOUT_VAL) begin
                  state_d  = afterStrobe;
                  cnt_d    = '0;
                  busErr_d = 1'b1;
               end
`else
               state_d = afterStrobe;
               cnt_d   = '0;
`endif
            end
         end
         RECOVER: begin
            if (cnt_q == RECOVER_LAST) begin
               state_d = CTRL_RESET;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CTRL_RESET: state_d = IDLE;
         default:    state_d = IDLE;
      endcase

      // A final strobe cycle may only complete (and strobe read data) once the channel is ready
      armed_d     = (state_d == STROBE) && (cnt_d == strobeLast) && rdyOk;
      addrLoad_d  = !(state_d == ADDR);
      dataLoad_d  = !((state_d == WDATA) || ((state_d == STROBE) && isRead_d && armed_d));
      iow_d       = !((state_d == STROBE) && !isRead_d && !isMem_d);
      ior_d       = !((state_d == STROBE) &&  isRead_d && !isMem_d);
      memw_d      = !((state_d == STROBE) && !isRead_d &&  isMem_d);
      memr_d      = !((state_d == STROBE) &&  isRead_d &&  isMem_d);
      ctrlReset_d = !(state_d == CTRL_RESET);
      busy_d      = (state_d != IDLE);
   end

   assign address_load  = addrLoad_q;
   assign data_load     = dataLoad_q;
   assign IOW           = iow_q;
   assign IOR           = ior_q;
   assign MEMW          = memw_q;
   assign MEMR          = memr_q;
   assign control_reset = ctrlReset_q;
   assign busy          = busy_q;
   assign bus_error     = busErr_q;

endmodule

// File: tb/tb_isa_bus_sequencer.sv
// Scoreboard bench for isa_bus_sequencer: expected per-cycle output vectors are queued per request.
// Vector order: {address_load, data_load, IOW, IOR, MEMW, MEMR, control_reset, busy, bus_error}.
module tb_isa_bus_sequencer;

   logic       clk = 1'b0;
   logic       rstN;
   logic [7:0] ctrl0, ctrl1;
   logic       rdy0, rdy1;
   logic       al0, dl0, iow0, ior0, mw0, mr0, cr0, busy0, err0;
   logic       al1, dl1, iow1, ior1, mw1, mr1, cr1, busy1, err1;
   logic [8:0] obs0, obs1;
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic       idleErr0, idleErr1;
   int         checks = 0;
   int         errors = 0;
   int         cycleNo = 0;

   always #5 clk = ~clk;

   isa_bus_sequencer #(.TIMEOUT_CYCLES(16)) dut0 (
      .clk(clk), .reset(rstN), .control_in(ctrl0), .iochrdy(rdy0),
      .address_load(al0), .data_load(dl0), .IOW(iow0), .IOR(ior0), .MEMW(mw0), .MEMR(mr0),
      .control_reset(cr0), .busy(busy0), .bus_error(err0)
   );

   isa_bus_sequencer #(.SETUP_CYCLES(2), .WRITE_STROBE_CYCLES(2), .RECOVERY_CYCLES(3)) dut1 (
      .clk(clk), .reset(rstN), .control_in(ctrl1), .iochrdy(rdy1),
      .address_load(al1), .data_load(dl1), .IOW(iow1), .IOR(ior1), .MEMW(mw1), .MEMR(mr1),
      .control_reset(cr1), .busy(busy1), .bus_error(err1)
   );

   assign obs0 = {al0, dl0, iow0, ior0, mw0, mr0, cr0, busy0, err0};
   assign obs1 = {al1, dl1, iow1, ior1, mw1, mr1, cr1, busy1, err1};

   function automatic logic [8:0] vec(input bit a, d, w, r, mw, mr, cr, b, e);
      return {a, d, w, r, mw, mr, cr, b, e};
   endfunction

   // One accepted request: setup, optional data phase, strobe, recovery, control reset, then idle
   function automatic void pushTxn(input int dutSel, input bit rd, input bit mem, input int setup,
                                   input int strobeLen, input bit lastData, input int rec,
                                   input bit errAfter);
      logic [8:0] items[$];
      bit         dl;
      for (int i = 0; i < setup; i++) items.push_back(vec(0, 1, 1, 1, 1, 1, 1, 1, 0));
      if (!rd) items.push_back(vec(1, 0, 1, 1, 1, 1, 1, 1, 0));
      for (int i = 0; i < strobeLen; i++) begin
         dl = !(rd && lastData && (i == strobeLen - 1));
         items.push_back(vec(1, dl, !(!rd && !mem), !(rd && !mem), !(!rd && mem), !(rd && mem), 1, 1, 0));
      end
      for (int i = 0; i < rec; i++) items.push_back(vec(1, 1, 1, 1, 1, 1, 1, 1, errAfter));
      items.push_back(vec(1, 1, 1, 1, 1, 1, 0, 1, errAfter));
      items.push_back(vec(1, 1, 1, 1, 1, 1, 1, 0, errAfter));
      foreach (items[i]) begin
         if (dutSel == 0) q0.push_back(items[i]);
         else             q1.push_back(items[i]);
      end
      if (dutSel == 0) idleErr0 = errAfter;
      else             idleErr1 = errAfter;
   endfunction

   task automatic checkOne(input string tag, input logic [8:0] observed, input logic [8:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d observed=%b expected=%b", tag, cycleNo, observed, expected);
      end
   endtask

   task automatic checkOutput(input int n);
      logic [8:0] exp0, exp1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cycleNo++;
         exp0 = (q0.size() > 0) ? q0.pop_front() : vec(1, 1, 1, 1, 1, 1, 1, 0, idleErr0);
         exp1 = (q1.size() > 0) ? q1.pop_front() : vec(1, 1, 1, 1, 1, 1, 1, 0, idleErr1);
         checkOne("dut0", obs0, exp0);
         checkOne("dut1", obs1, exp1);
      end
   endtask

   task automatic drain(input int extra);
      int budget = 0;
      while ((q0.size() > 0 || q1.size() > 0) && budget < 400) begin
         checkOutput(1);
         budget++;
      end
      checkOutput(extra);
   endtask

   // Request is presented before edge 0 and withdrawn just after it
   task automatic applyStimulus(input logic [7:0] c0, input logic [7:0] c1);
      ctrl0   = c0;
      ctrl1   = c1;
      cycleNo = 0;
      @(posedge clk);
      #1;
      ctrl0 = 8'h00;
      ctrl1 = 8'h00;
   endtask

   initial begin
      rstN     = 1'b0;
      ctrl0    = 8'h00;
      ctrl1    = 8'h00;
      rdy0     = 1'b1;
      rdy1     = 1'b1;
      idleErr0 = 1'b0;
      idleErr1 = 1'b0;

      checkOutput(2);
      rstN = 1'b1;
      checkOutput(2);

      pushTxn(0, 0, 0, 1, 4, 0, 0, 0);
      pushTxn(1, 0, 0, 2, 2, 0, 3, 0);
      applyStimulus(8'h02, 8'h02);
      drain(1);

      pushTxn(0, 1, 0, 1, 5, 1, 0, 0);
      pushTxn(1, 1, 1, 2, 5, 1, 3, 0);
      applyStimulus(8'h01, 8'h05);
      drain(1);

      pushTxn(0, 0, 1, 1, 4, 0, 0, 0);
      pushTxn(1, 1, 0, 2, 5, 1, 3, 0);
      applyStimulus(8'h06, 8'h03);
      drain(1);

      pushTxn(0, 1, 1, 1, 5, 1, 0, 0);
      applyStimulus(8'h05, 8'hF8);
      drain(1);

      pushTxn(0, 1, 0, 1, 5, 1, 0, 0);
      pushTxn(1, 0, 1, 2, 2, 0, 3, 0);
      applyStimulus(8'hFB, 8'hFE);
      drain(1);

      // A request left set through the return to IDLE starts a second cycle
      pushTxn(0, 0, 0, 1, 4, 0, 0, 0);
      pushTxn(0, 0, 0, 1, 4, 0, 0, 0);
      ctrl0   = 8'h02;
      cycleNo = 0;
      checkOutput(9);
      ctrl0 = 8'h00;
      drain(1);

`ifdef IOCHRDY_EN
      // iochrdy low during cycles 3-12: four normal IOR cycles, ten waits, one completing cycle
      pushTxn(0, 1, 0, 1, 15, 1, 0, 0);
      applyStimulus(8'h01, 8'h00);
      checkOutput(2);
      rdy0 = 1'b0;
      checkOutput(10);
      rdy0 = 1'b1;
      drain(2);

      rdy0 = 1'b0;
      checkOutput(3);
      pushTxn(0, 1, 0, 1, 20, 0, 0, 1);
      applyStimulus(8'h01, 8'h00);
      drain(0);
      rdy0 = 1'b1;
      checkOutput(3);
      pushTxn(0, 0, 0, 1, 4, 0, 0, 0);
      applyStimulus(8'h02, 8'h00);
      drain(1);
`else
      rdy0 = 1'b0;
      checkOutput(3);
      pushTxn(0, 1, 0, 1, 5, 1, 0, 0);
      applyStimulus(8'h01, 8'h00);
      drain(1);
      rdy0 = 1'b1;
`endif

      // Reset in the middle of the read strobe abandons the cycle at once
      pushTxn(0, 1, 0, 1, 5, 1, 0, 0);
      applyStimulus(8'h01, 8'h00);
      checkOutput(4);
      #2;
      rstN = 1'b0;
      #1;
      checkOne("dut0 async reset", obs0, vec(1, 1, 1, 1, 1, 1, 1, 0, 0));
      q0.delete();
      idleErr0 = 1'b0;
      checkOutput(2);
      rstN = 1'b1;
      checkOutput(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isa_bus_sequencer.md
Name: isa_bus_sequencer

Overview:
- Parametrised successor to the riser's fixed-timing ISA bus cycle state machine.
- Sequences one ISA I/O or memory read/write per request, with per-phase cycle counts set by parameters.
- Adds memory-space strobes, a recovery phase, busy/error status, and optional IOCHRDY wait-state extension with timeout.
- Sits between the host-side control register and the ISA strobe/latch drivers.

Parameters:
SETUP_CYCLES, 1, cycles address_load held low (>=1)
WRITE_STROBE_CYCLES, 4, cycles IOW/MEMW held low (>=1)
READ_STROBE_CYCLES, 5, cycles IOR/MEMR held low (>=1)
RECOVERY_CYCLES, 0, idle-strobe cycles before control_reset (>=0)
TIMEOUT_CYCLES, 64, max IOCHRDY wait cycles (>=1, used only with IOCHRDY_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
control_in  in  8  bit0 read req, bit1 write req, bit2 space (0 I/O, 1 memory), bits7:3 ignored
iochrdy  in  1  ISA channel ready, asynchronous; ignored without IOCHRDY_EN
address_load  out  1  active-low address latch enable
data_load  out  1  active-low data latch enable
IOW  out  1  active-low I/O write strobe
IOR  out  1  active-low I/O read strobe
MEMW  out  1  active-low memory write strobe
MEMR  out  1  active-low memory read strobe
control_reset  out  1  active-low one-cycle clear of control register
busy  out  1  high while a cycle is in progress
bus_error  out  1  sticky, high after a timed-out cycle

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low, on port reset.
- Outputs are registered, decoded from the state being entered, so they change on the same edge as the state. No combinational glitches on strobes.
- Reset values: all active-low outputs 1; busy 0; bus_error 0; state IDLE; counters 0. Asserting reset mid-cycle releases all strobes immediately and the cycle is abandoned.
- States: IDLE, ADDR, WDATA, STROBE, RECOVER, CTRL_RESET.
- IDLE: samples control_in each edge.
  - bit0 or bit1 set -> ADDR. Latch direction and space at this edge.
  - If bit0 and bit1 are both set, read wins.
  - Clear bus_error on this edge.
- ADDR: address_load=0 for SETUP_CYCLES. Then write -> WDATA, read -> STROBE.
- WDATA (write only): data_load=0 for 1 cycle -> STROBE.
- STROBE: the strobe selected by direction and space is low for WRITE_STROBE_CYCLES or READ_STROBE_CYCLES.
  - Read: data_load=0 in the final strobe cycle only.
  - Then -> RECOVER if RECOVERY_CYCLES>0, else -> CTRL_RESET.
- RECOVER: all strobes high for RECOVERY_CYCLES.
- CTRL_RESET: control_reset=0 for 1 cycle -> IDLE.
- control_in changes after acceptance are ignored until IDLE. A request still set on return to IDLE starts a new cycle. Upstream clears it via control_reset.
- busy=1 in every state except IDLE.
- Phase counters are sized to $clog2 of the largest parameter +1. Each counter loads at phase entry and terminates at count-1, so there is no wrap.
- Default parameters reproduce legacy timing exactly:
  - write: addr 1, data 1, IOW 4, control_reset 1.
  - read: addr 1, IOR 5 with data_load in the 5th, control_reset 1.

Optional Feature:
IOCHRDY_EN
- Defined:
  - iochrdy passes through a 2-flop synchroniser.
  - In the final STROBE cycle, if synced iochrdy=0, STROBE holds (strobe low, read data_load withheld) and a wait counter increments.
  - The cycle completes normally (read: data_load=0) in the first final-cycle edge with synced iochrdy=1.
  - Wait counter reaching TIMEOUT_CYCLES: strobe released, data_load never asserted, bus_error set, flow continues RECOVER/CTRL_RESET as normal.
- Undefined: iochrdy is ignored, no synchroniser, no wait counter, bus_error stays 0.

Test Plan:
- Defaults, control_in=0x02 accepted at edge 0 -> address_load low cycle 1; data_load low cycle 2; IOW low cycles 3-6; control_reset low cycle 7; busy=0 cycle 8.
- control_in=0x01 -> address_load low cycle 1; IOR low cycles 2-6; data_load low cycle 6 only; control_reset low cycle 7.
- control_in=0x06 then 0x05 -> MEMW/MEMR used, IOW/IOR stay 1. control_in=0x03 -> read sequence.
- SETUP_CYCLES=2, WRITE_STROBE_CYCLES=2, RECOVERY_CYCLES=3, write -> address_load cycles 1-2; data_load 3; IOW 4-5; all high 6-8; control_reset 9.
- IOCHRDY_EN, read, iochrdy low from cycle 3 for 10 cycles -> IOR extends, ending 2 cycles (synchroniser delay) after iochrdy rises; data_load low in last IOR cycle.
- IOCHRDY_EN, TIMEOUT_CYCLES=16, iochrdy stuck low -> IOR released after 16 wait cycles; no data_load; bus_error=1 until next accept. reset low mid-STROBE -> all outputs 1 immediately.
